// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: expands one 512-bit SHA-256 message block into the 64-word schedule
// W0..W63 and presents it on a 2048-bit bus (Wi at [2047-32*i -: 32]).
// Start/busy/done sequencer: IDLE -> EXPAND -> DONE -> IDLE.
// WPC (1 or 2) schedule words are produced per expansion cycle; expansion takes 48/WPC cycles.
// Optional build macro MSGSCHED_BYTESWAP_EN: byte-reverses each input word before it is loaded
// (for little-endian header fields). Expansion is unaffected.
module sha256_msg_schedule #(
  parameter int unsigned WPC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [511:0]  block_in,
  output logic [2047:0] schedule_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Schedule words held as a packed array so element 0 lands in the top 32 bits of the bus.
  logic [0:63][31:0] w;
  logic [6:0]        t;
  logic [5:0]        tw;
  logic [511:0]      blk_ld;
  logic [31:0]       w_new0, w_new1;
  logic              last;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef MSGSCHED_BYTESWAP_EN
  for (genvar g = 0; g < 16; g++) begin : g_bswap
    logic [31:0] x;
    assign x = block_in[511-32*g -: 32];
    assign blk_ld[511-32*g -: 32] = {x[7:0], x[15:8], x[23:16], x[31:24]};
  end
`else
  assign blk_ld = block_in;
`endif

  assign schedule_out = w;
  assign tw           = t[5:0];
  assign last         = (t == 7'(64 - WPC));

  // Next schedule word(s); W[t+1] depends only on already-stored words, so both can be written together.
  always_comb begin
    w_new0 = sig1(w[tw - 6'd2]) + w[tw - 6'd7] + sig0(w[tw - 6'd15]) + w[tw - 6'd16];
    w_new1 = sig1(w[tw - 6'd1]) + w[tw - 6'd6] + sig0(w[tw - 6'd14]) + w[tw - 6'd15];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  begin
                 busy = 1'b1;
                 if (last) state_nxt = DONE;
               end
      DONE:    begin
                 busy      = 1'b1;
                 done      = 1'b1;
                 state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  // Schedule storage and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      w <= '0;
      t <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w <= {blk_ld, 1536'b0};
            t <= 7'd16;
          end
        end
        EXPAND: begin
          w[tw] <= w_new0;
          if (WPC == 2) w[tw + 6'd1] <= w_new1;
          t <= t + 7'(WPC);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: randomized and known-answer checks of sha256_msg_schedule
// for WPC=1 and WPC=2 against a behavioural schedule model.
module tb_sha256_msg_schedule;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start1 = 1'b0;
  logic          start2 = 1'b0;
  logic [511:0]  block_in = '0;
  logic [2047:0] out1, out2;
  logic          busy1, busy2, done1, done2;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_accept = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_msg_schedule #(.WPC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .block_in(block_in),
    .schedule_out(out1), .busy(busy1), .done(done1)
  );

  sha256_msg_schedule #(.WPC(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .block_in(block_in),
    .schedule_out(out2), .busy(busy2), .done(done2)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] word_of(input logic [2047:0] bus, input int i);
    return 32'(bus >> (32 * (63 - i)));
  endfunction

  function automatic logic [2047:0] ref_sched(input logic [511:0] blk);
    logic [31:0] wq[$];
    logic [31:0] x;
    logic [2047:0] r;
    for (int i = 0; i < 16; i++) begin
      x = 32'(blk >> (32 * (15 - i)));
`ifdef MSGSCHED_BYTESWAP_EN
      x = {x[7:0], x[15:8], x[23:16], x[31:24]};
`endif
      wq.push_back(x);
    end
    for (int i = 16; i < 64; i++)
      wq.push_back(ms1(wq[i-2]) + wq[i-7] + ms0(wq[i-15]) + wq[i-16]);
    r = '0;
    for (int i = 0; i < 64; i++) r = {r[2015:0], wq[i]};
    return r;
  endfunction

  function automatic logic [511:0] abc_block();
`ifdef MSGSCHED_BYTESWAP_EN
    return {32'h80636261, 448'h0, 32'h18000000};
`else
    return {32'h61626380, 448'h0, 32'h00000018};
`endif
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    b = '0;
    for (int j = 0; j < 16; j++) b = {b[479:0], 32'($urandom)};
    return b;
  endfunction

  function automatic int first_diff(input logic [2047:0] a, input logic [2047:0] b);
    for (int i = 0; i < 64; i++)
      if (word_of(a, i) !== word_of(b, i)) return i;
    return 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    block_in = rand_block();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Starts one block on the selected instance and follows it until done falls (bounded).
  task automatic run(input int sel, input logic [511:0] blk, output int lat, output int width,
                     output logic [2047:0] res, output bit busy_ok);
    logic d, b;
    block_in = blk;
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    last_accept = cyc;
    start1 = 1'b0; start2 = 1'b0;
    block_in = rand_block();
    lat = -1; width = 0; res = '0; busy_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      d = (sel == 1) ? done1 : done2;
      b = (sel == 1) ? busy1 : busy2;
      if (d) begin
        if (lat < 0) begin
          lat = n;
          res = (sel == 1) ? out1 : out2;
        end
        width++;
      end else begin
        if (lat >= 0) break;
        if (!b) busy_ok = 1'b0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out1 !== '0) $display("FAIL reset_out1: word %0d got %h want 0", first_diff(out1, '0), word_of(out1, first_diff(out1, '0))); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b want 0", busy1); else passed++;
    checks++; if (done1 !== 1'b0) $display("FAIL reset_done1: got %b want 0", done1); else passed++;
    checks++; if (out2 !== '0) $display("FAIL reset_out2: word %0d got %h want 0", first_diff(out2, '0), word_of(out2, first_diff(out2, '0))); else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy2: got %b want 0", busy2); else passed++;
    checks++; if (done2 !== 1'b0) $display("FAIL reset_done2: got %b want 0", done2); else passed++;
  endtask

  task automatic test_abc();
    int lat, width;
    logic [2047:0] r1, r2, exp_s;
    bit bok;
    exp_s = ref_sched(abc_block());
    run(1, abc_block(), lat, width, r1, bok);
    checks++; if (lat !== 48) $display("FAIL abc1_latency: got %0d want 48", lat); else passed++;
    checks++; if (width !== 1) $display("FAIL abc1_done_width: got %0d want 1", width); else passed++;
    checks++; if (!bok) $display("FAIL abc1_busy: got busy low during expansion want high"); else passed++;
    checks++; if (word_of(r1, 0) !== 32'h61626380) $display("FAIL abc_w0: got %h want 61626380", word_of(r1, 0)); else passed++;
    checks++; if (word_of(r1, 15) !== 32'h00000018) $display("FAIL abc_w15: got %h want 00000018", word_of(r1, 15)); else passed++;
    checks++; if (word_of(r1, 16) !== 32'h61626380) $display("FAIL abc_w16: got %h want 61626380", word_of(r1, 16)); else passed++;
    checks++; if (word_of(r1, 17) !== 32'h000f0000) $display("FAIL abc_w17: got %h want 000f0000", word_of(r1, 17)); else passed++;
    checks++; if (word_of(r1, 63) !== 32'h12b1edeb) $display("FAIL abc_w63: got %h want 12b1edeb", word_of(r1, 63)); else passed++;
    checks++; if (r1 !== exp_s) $display("FAIL abc1_sched: word %0d got %h want %h", first_diff(r1, exp_s), word_of(r1, first_diff(r1, exp_s)), word_of(exp_s, first_diff(r1, exp_s))); else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (out1 !== exp_s) $display("FAIL abc1_hold: word %0d got %h want %h", first_diff(out1, exp_s), word_of(out1, first_diff(out1, exp_s)), word_of(exp_s, first_diff(out1, exp_s))); else passed++;
    run(2, abc_block(), lat, width, r2, bok);
    checks++; if (lat !== 24) $display("FAIL abc2_latency: got %0d want 24", lat); else passed++;
    checks++; if (width !== 1) $display("FAIL abc2_done_width: got %0d want 1", width); else passed++;
    checks++; if (r2 !== exp_s) $display("FAIL abc2_sched: word %0d got %h want %h", first_diff(r2, exp_s), word_of(r2, first_diff(r2, exp_s)), word_of(exp_s, first_diff(r2, exp_s))); else passed++;
  endtask

  task automatic test_zero();
    int lat, width;
    logic [2047:0] r;
    bit bok;
    for (int sel = 1; sel <= 2; sel++) begin
      run(sel, '0, lat, width, r, bok);
      checks++; if (r !== '0) $display("FAIL zero_sched%0d: word %0d got %h want 0", sel, first_diff(r, '0), word_of(r, first_diff(r, '0))); else passed++;
      checks++; if (width !== 1) $display("FAIL zero_done_width%0d: got %0d want 1", sel, width); else passed++;
    end
  endtask

  task automatic test_random();
    int lat, width, want_lat;
    logic [2047:0] r, exp_s;
    logic [511:0] blk;
    bit bok;
    for (int k = 0; k < 6; k++) begin
      int sel;
      sel = (k % 2) + 1;
      want_lat = (sel == 1) ? 48 : 24;
      blk = rand_block();
      exp_s = ref_sched(blk);
      run(sel, blk, lat, width, r, bok);
      checks++; if (lat !== want_lat) $display("FAIL rand%0d_latency: got %0d want %0d", k, lat, want_lat); else passed++;
      checks++; if (r !== exp_s) $display("FAIL rand%0d_sched: word %0d got %h want %h", k, first_diff(r, exp_s), word_of(r, first_diff(r, exp_s)), word_of(exp_s, first_diff(r, exp_s))); else passed++;
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [2047:0] r, exp_s;
    exp_s = ref_sched(abc_block());
    block_in = abc_block();
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = -1; r = '0;
    for (int n = 1; n <= 100; n++) begin
      start1 = (n >= 9 && n <= 11) ? 1'b1 : 1'b0;
      if (n == 9) block_in = rand_block();
      @(posedge clk);
      #1;
      if (n == 20) begin
        checks++; if (word_of(out1, 0) !== word_of(exp_s, 0)) $display("FAIL ignore_w0_mid: got %h want %h", word_of(out1, 0), word_of(exp_s, 0)); else passed++;
      end
      if (done1 && lat < 0) begin lat = n; r = out1; end
      if (!done1 && lat >= 0) break;
    end
    start1 = 1'b0;
    checks++; if (lat !== 48) $display("FAIL ignore_latency: got %0d want 48", lat); else passed++;
    checks++; if (r !== exp_s) $display("FAIL ignore_sched: word %0d got %h want %h", first_diff(r, exp_s), word_of(r, first_diff(r, exp_s)), word_of(exp_s, first_diff(r, exp_s))); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, width, dones;
    logic [2047:0] r, exp_s;
    logic [511:0] blk;
    bit bok;
    blk = rand_block();
    block_in = blk;
    start1 = 1'b1; start2 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0; start2 = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out1 !== '0) $display("FAIL midrst_out1: word %0d got %h want 0", first_diff(out1, '0), word_of(out1, first_diff(out1, '0))); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL midrst_busy1: got %b want 0", busy1); else passed++;
    checks++; if (out2 !== '0) $display("FAIL midrst_out2: word %0d got %h want 0", first_diff(out2, '0), word_of(out2, first_diff(out2, '0))); else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL midrst_busy2: got %b want 0", busy2); else passed++;
    dones = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (done1 || done2) dones++;
    end
    checks++; if (dones !== 0) $display("FAIL midrst_no_done: got %0d done cycles want 0", dones); else passed++;
    exp_s = ref_sched(blk);
    run(1, blk, lat, width, r, bok);
    checks++; if (lat !== 48) $display("FAIL midrst_restart_latency: got %0d want 48", lat); else passed++;
    checks++; if (r !== exp_s) $display("FAIL midrst_restart_sched: word %0d got %h want %h", first_diff(r, exp_s), word_of(r, first_diff(r, exp_s)), word_of(exp_s, first_diff(r, exp_s))); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, width, acc_a, period;
    logic [2047:0] r, exp_s;
    logic [511:0] blk_a, blk_b;
    bit bok;
    for (int sel = 1; sel <= 2; sel++) begin
      blk_a = rand_block();
      blk_b = rand_block();
      run(sel, blk_a, lat, width, r, bok);
      acc_a = last_accept;
      exp_s = ref_sched(blk_a);
      checks++; if (r !== exp_s) $display("FAIL b2b%0d_first: word %0d got %h want %h", sel, first_diff(r, exp_s), word_of(r, first_diff(r, exp_s)), word_of(exp_s, first_diff(r, exp_s))); else passed++;
      run(sel, blk_b, lat, width, r, bok);
      period = last_accept - acc_a;
      exp_s = ref_sched(blk_b);
      checks++; if (period !== ((sel == 1) ? 50 : 26)) $display("FAIL b2b%0d_period: got %0d want %0d", sel, period, (sel == 1) ? 50 : 26); else passed++;
      checks++; if (lat !== ((sel == 1) ? 48 : 24)) $display("FAIL b2b%0d_latency: got %0d want %0d", sel, lat, (sel == 1) ? 48 : 24); else passed++;
      checks++; if (r !== exp_s) $display("FAIL b2b%0d_second: word %0d got %h want %h", sel, first_diff(r, exp_s), word_of(r, first_diff(r, exp_s)), word_of(exp_s, first_diff(r, exp_s))); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
